// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared constants for the data-memory port-B arbiter.
// Holds the 2-bit arbiter state encoding and the 1-bit read-owner tag values.
package dmem_port_arbiter_pkg;
  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_CPU_OWN     = 2'd1;
  localparam logic [1:0] ST_HOST_OWN    = 2'd2;
  localparam logic [1:0] ST_HOST_LOCKED = 2'd3;
  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;
endpackage

// File: rtl/dmem_port_arbiter_rd_tag.sv
// dmem_rd_tag: tags an issued BRAM read with its owner and steers the returning data.
// Ports: clk, rst (async, active high); issue_i (read beat granted), owner_i (OWN_CPU/OWN_HOST);
// bram_dob_i (BRAM data, one cycle after the address); cpu_/host_ rvalid_o, rdata_o.
// Each rdata shows bram_dob during its rvalid cycle and otherwise holds the last returned word.
module dmem_rd_tag
  import dmem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_i,
  input  logic              owner_i,
  input  logic [DATA_W-1:0] bram_dob_i,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o
);
  logic              valid_q, owner_q;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d, host_hold_q, host_hold_d;
  assign cpu_rvalid_o  = valid_q && owner_q == OWN_CPU;
  assign host_rvalid_o = valid_q && owner_q == OWN_HOST;
  assign cpu_rdata_o   = cpu_rvalid_o ? bram_dob_i : cpu_hold_q;
  assign host_rdata_o  = host_rvalid_o ? bram_dob_i : host_hold_q;
  assign cpu_hold_d    = cpu_rdata_o;
  assign host_hold_d   = host_rdata_o;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q     <= 1'b0;
      owner_q     <= OWN_CPU;
      cpu_hold_q  <= '0;
      host_hold_q <= '0;
    end else begin
      valid_q     <= issue_i;
      owner_q     <= owner_i;
      cpu_hold_q  <= cpu_hold_d;
      host_hold_q <= host_hold_d;
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares BRAM port B between the CPU MEM stage and a host loader/debug master.
// Ports: clk, rst (async, active high); cpu_* request/stall/read-return; host_* request/lock/
// grant/read-return; bram_web_o/bram_addrb_o/bram_dib_o to port B, bram_dob_i from port B.
// CPU has priority except while the host holds a burst lock.
// Optional macro DMEM_ARB_STARVE_GUARD_EN: host forced in after STARVE_LIMIT losing cycles.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_i,
  input  logic [DATA_W/8-1:0] cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_wdata_i,
  output logic                cpu_stall_o,
  output logic                cpu_rvalid_o,
  output logic [DATA_W-1:0]   cpu_rdata_o,
  input  logic                host_req_i,
  input  logic                host_lock_i,
  input  logic [DATA_W/8-1:0] host_we_i,
  input  logic [ADDR_W-1:0]   host_addr_i,
  input  logic [DATA_W-1:0]   host_wdata_i,
  output logic                host_gnt_o,
  output logic                host_rvalid_o,
  output logic [DATA_W-1:0]   host_rdata_o,
  output logic [DATA_W/8-1:0] bram_web_o,
  output logic [ADDR_W-1:0]   bram_addrb_o,
  output logic [DATA_W-1:0]   bram_dib_o,
  input  logic [DATA_W-1:0]   bram_dob_i
);
  logic [1:0] state_q, state_d;
  logic       cpu_grant, host_grant, force_host, rd_issue;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic [7:0] starve_q, starve_d;
  assign force_host = starve_q == 8'(STARVE_LIMIT);
  assign starve_d   = host_grant ? 8'd0 : (host_req_i && starve_q != 8'hFF) ? starve_q + 8'd1 : starve_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_q <= 8'd0;
    else     starve_q <= starve_d;
`else
  assign force_host = 1'b0;
`endif
  // Nothing is granted while reset is held, so the BRAM never sees a write in reset.
  assign host_grant = !rst && host_req_i && (state_q == ST_HOST_LOCKED || !cpu_req_i || force_host);
  assign cpu_grant  = !rst && cpu_req_i && !host_grant;
  // A locked host dropping its request falls straight into the idle rules above, so no dead cycle.
  assign state_d = cpu_grant                  ? ST_CPU_OWN :
                   !host_grant                ? ST_IDLE :
                   host_lock_i                ? ST_HOST_LOCKED :
                   state_q == ST_HOST_LOCKED  ? ST_IDLE : ST_HOST_OWN;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  assign cpu_stall_o  = cpu_req_i && !cpu_grant;
  assign host_gnt_o   = host_grant;
  assign bram_web_o   = host_grant ? host_we_i : cpu_grant ? cpu_we_i : '0;
  assign bram_addrb_o = host_grant ? host_addr_i : cpu_addr_i;
  assign bram_dib_o   = host_grant ? host_wdata_i : cpu_wdata_i;
  assign rd_issue     = (host_grant && host_we_i == '0) || (cpu_grant && cpu_we_i == '0);
  dmem_rd_tag #(.DATA_W(DATA_W)) u_rd_tag (
    .clk          (clk),
    .rst          (rst),
    .issue_i      (rd_issue),
    .owner_i      (host_grant ? OWN_HOST : OWN_CPU),
    .bram_dob_i   (bram_dob_i),
    .cpu_rvalid_o (cpu_rvalid_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rdata_o (host_rdata_o)
  );
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_port_arbiter;
  localparam int LIMIT = 3;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        cpu_req, host_req, host_lock;
  logic [3:0]  cpu_we, host_we;
  logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata, bram_dob;
  logic        cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
  logic [31:0] cpu_rdata, host_rdata, bram_addrb, bram_dib;
  logic [3:0]  bram_web;
  int tests = 0, fails = 0;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_stall_o(cpu_stall), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .host_req_i(host_req), .host_lock_i(host_lock), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .bram_web_o(bram_web), .bram_addrb_o(bram_addrb), .bram_dib_o(bram_dib), .bram_dob_i(bram_dob)
  );

  // Behavioural model: who holds a burst lock, which requester (if any) has a read in flight,
  // last data each requester received, and how long the host has been losing.
  bit          m_lock, m_hw, m_cw, guard;
  int          m_rd, m_starve;
  logic [31:0] m_cpu_hold, m_host_hold;
  logic [135:0] exp_v;
  wire  [135:0] obs_v = {cpu_stall, host_gnt, bram_web, bram_addrb, bram_dib, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata};

  task model_reset();
    m_lock = 0; m_rd = -1; m_starve = 0; m_cpu_hold = '0; m_host_hold = '0;
  endtask

  task eval();
    guard = 0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    guard = (m_starve == LIMIT);
`endif
    m_hw = !rst && host_req && (m_lock || !cpu_req || guard);
    m_cw = !rst && cpu_req && !m_hw;
    exp_v = {cpu_req && !m_cw, m_hw,
             m_hw ? host_we : m_cw ? cpu_we : 4'h0,
             m_hw ? host_addr : cpu_addr,
             m_hw ? host_wdata : cpu_wdata,
             m_rd == 0, m_rd == 1,
             m_rd == 0 ? bram_dob : m_cpu_hold,
             m_rd == 1 ? bram_dob : m_host_hold};
  endtask

  task settle();
    @(negedge clk);
    eval();
  endtask

  task advance();
    @(posedge clk);
    if (!rst) begin
      if (m_rd == 0) m_cpu_hold = bram_dob;
      if (m_rd == 1) m_host_hold = bram_dob;
      m_rd = (m_hw && host_we == 0) ? 1 : (m_cw && cpu_we == 0) ? 0 : -1;
      m_lock = m_hw && host_lock;
      m_starve = m_hw ? 0 : (host_req && m_starve < 255) ? m_starve + 1 : m_starve;
    end
    #1;
  endtask

  task idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_lock = 0; host_we = 0; host_addr = 0; host_wdata = 0; bram_dob = 0;
  endtask

  task test_reset();
    idle_inputs(); rst = 1; model_reset();
    settle();
    tests++;
    if ({cpu_stall, host_gnt, bram_web, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata} !== '0) begin
      fails++; $display("FAIL reset: outputs %h required 0", {cpu_stall, host_gnt, bram_web, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata});
    end
    advance(); rst = 0;
  endtask

  task test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    settle();
    tests++;
    if ({cpu_stall, bram_web, bram_addrb} !== {1'b0, 4'h0, 32'h40}) begin
      fails++; $display("FAIL cpu_read_issue: stall/web/addr %h required %h", {cpu_stall, bram_web, bram_addrb}, {1'b0, 4'h0, 32'h40});
    end
    advance(); cpu_req = 0; bram_dob = 32'hDEADBEEF;
    settle();
    tests++;
    if ({cpu_rvalid, cpu_rdata, host_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      fails++; $display("FAIL cpu_read_return: rvalid/rdata/host_rvalid %h required %h", {cpu_rvalid, cpu_rdata, host_rvalid}, {1'b1, 32'hDEADBEEF, 1'b0});
    end
    advance();
  endtask

  task test_conflict();
    cpu_req = 1; cpu_we = 4'h3; cpu_addr = 32'h100; cpu_wdata = 32'hA5A5_0001;
    host_req = 1; host_lock = 0; host_we = 4'hF; host_addr = 32'h200; host_wdata = 32'h5A5A_0002;
    repeat (2) begin
      settle();
      tests++;
      if ({bram_web, host_gnt, cpu_stall, bram_addrb} !== {4'h3, 1'b0, 1'b0, 32'h100}) begin
        fails++; $display("FAIL conflict_cpu_wins: web/gnt/stall/addr %h required %h", {bram_web, host_gnt, cpu_stall, bram_addrb}, {4'h3, 1'b0, 1'b0, 32'h100});
      end
      advance();
    end
    cpu_req = 0;
    settle();
    tests++;
    if ({host_gnt, bram_web, bram_addrb, bram_dib} !== {1'b1, 4'hF, 32'h200, 32'h5A5A_0002}) begin
      fails++; $display("FAIL conflict_host_after: gnt/web/addr/data %h required %h", {host_gnt, bram_web, bram_addrb, bram_dib}, {1'b1, 4'hF, 32'h200, 32'h5A5A_0002});
    end
    advance(); host_req = 0;
  endtask

  task test_host_burst();
    cpu_req = 0; cpu_we = 4'hC; cpu_addr = 32'h80;
    host_req = 1; host_lock = 1; host_we = 4'hF; host_addr = 32'h0;
    settle();
    tests++;
    if (host_gnt !== 1'b1) begin
      fails++; $display("FAIL burst_acquire: host_gnt %b required 1", host_gnt);
    end
    advance();
    cpu_req = 1;
    for (int i = 0; i < 4; i++) begin
      host_addr = 32'(i * 4); host_lock = (i != 3); host_wdata = 32'(i);
      settle();
      tests++;
      if ({host_gnt, cpu_stall, bram_web, bram_addrb} !== {1'b1, 1'b1, 4'hF, 32'(i * 4)}) begin
        fails++; $display("FAIL burst_beat%0d: gnt/stall/web/addr %h required %h", i, {host_gnt, cpu_stall, bram_web, bram_addrb}, {1'b1, 1'b1, 4'hF, 32'(i * 4)});
      end
      advance();
    end
    host_req = 0; host_lock = 0;
    settle();
    tests++;
    if ({cpu_stall, host_gnt, bram_web, bram_addrb} !== {1'b0, 1'b0, 4'hC, 32'h80}) begin
      fails++; $display("FAIL burst_release: stall/gnt/web/addr %h required %h", {cpu_stall, host_gnt, bram_web, bram_addrb}, {1'b0, 1'b0, 4'hC, 32'h80});
    end
    advance(); cpu_req = 0;
  endtask

  task test_interleaved();
    cpu_req = 0; host_req = 1; host_lock = 0; host_we = 0; host_addr = 32'h300;
    settle();
    tests++;
    if (host_gnt !== 1'b1) begin
      fails++; $display("FAIL interleave_host_issue: host_gnt %b required 1", host_gnt);
    end
    advance();
    host_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44; bram_dob = 32'h1111_2222;
    settle();
    tests++;
    if ({host_rvalid, host_rdata, cpu_rvalid, cpu_stall} !== {1'b1, 32'h1111_2222, 1'b0, 1'b0}) begin
      fails++; $display("FAIL interleave_host_data: hrv/hrd/crv/stall %h required %h", {host_rvalid, host_rdata, cpu_rvalid, cpu_stall}, {1'b1, 32'h1111_2222, 1'b0, 1'b0});
    end
    advance();
    cpu_req = 0; bram_dob = 32'h3333_4444;
    settle();
    tests++;
    if ({cpu_rvalid, cpu_rdata, host_rvalid, host_rdata} !== {1'b1, 32'h3333_4444, 1'b0, 32'h1111_2222}) begin
      fails++; $display("FAIL interleave_cpu_data: crv/crd/hrv/hrd %h required %h", {cpu_rvalid, cpu_rdata, host_rvalid, host_rdata}, {1'b1, 32'h3333_4444, 1'b0, 32'h1111_2222});
    end
    advance();
  endtask

  task test_reset_mid_read();
    cpu_req = 0; host_req = 1; host_lock = 1; host_we = 0; host_addr = 32'h10;
    settle();
    tests++;
    if (host_gnt !== 1'b1) begin
      fails++; $display("FAIL midreset_issue: host_gnt %b required 1", host_gnt);
    end
    advance();
    rst = 1; model_reset(); host_we = 4'hF; bram_dob = 32'hCAFE_F00D;
    settle();
    tests++;
    if ({cpu_rvalid, host_rvalid, cpu_rdata, host_rdata, bram_web, host_gnt, cpu_stall} !== '0) begin
      fails++; $display("FAIL midreset_outputs: %h required 0", {cpu_rvalid, host_rvalid, cpu_rdata, host_rdata, bram_web, host_gnt, cpu_stall});
    end
    advance(); rst = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; host_lock = 0;
    settle();
    tests++;
    if ({host_gnt, cpu_stall, host_rvalid} !== 3'b000) begin
      fails++; $display("FAIL midreset_idle: gnt/stall/hrv %b required 000", {host_gnt, cpu_stall, host_rvalid});
    end
    advance(); cpu_req = 0; host_req = 0;
  endtask

`ifdef DMEM_ARB_STARVE_GUARD_EN
  task test_starve();
    cpu_req = 0; host_req = 1; host_lock = 0; host_we = 4'h1;
    settle(); advance();
    cpu_req = 1; cpu_we = 0;
    for (int c = 1; c <= 5; c++) begin
      settle();
      tests++;
      if ({host_gnt, cpu_stall} !== {c == 4, c == 4}) begin
        fails++; $display("FAIL starve_cycle%0d: gnt/stall %b required %b", c, {host_gnt, cpu_stall}, {c == 4, c == 4});
      end
      advance();
    end
    cpu_req = 0; host_req = 0;
  endtask
`endif

  task test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) begin
        rst = 1; model_reset();
      end
      cpu_req = $urandom_range(1); host_req = $urandom_range(1); host_lock = $urandom_range(3) != 0;
      cpu_we = $urandom_range(1) ? 4'h0 : 4'($urandom); host_we = $urandom_range(1) ? 4'h0 : 4'($urandom);
      cpu_addr = $urandom; host_addr = $urandom; cpu_wdata = $urandom; host_wdata = $urandom; bram_dob = $urandom;
      settle();
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL random_cycle%0d: got %h required %h", n, obs_v, exp_v);
      end
      advance();
      rst = 0;
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_conflict();
    test_host_burst();
    test_interleaved();
    test_reset_mid_read();
`ifdef DMEM_ARB_STARVE_GUARD_EN
    test_starve();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
